// File: rtl/data_hs_fifo.sv
// DEPTH-entry show-ahead valid/ready FIFO between the data producer and consumer.
// Optional occupancy statistics (xfer_cnt, stall_cnt) are built only when DATA_HS_STATS_EN is defined.
module data_hs_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [WIDTH-1:0]       m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef DATA_HS_STATS_EN
  ,
  output logic [15:0]            xfer_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // s_ready is registered so it stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      s_ready <= (count_nxt != FULL_CNT);
    end
  end

`ifdef DATA_HS_STATS_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && (xfer_cnt != 16'hFFFF)) xfer_cnt <= xfer_cnt + 16'd1;
      if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/data_hs_fifo.md
# data_hs_fifo

Parametrised valid/ready stream buffer that replaces the direct single-register master-to-slave link in the data path with a DEPTH-entry show-ahead FIFO. The upstream producer writes through the s_* handshake and the downstream consumer reads through the m_* handshake. Both sides may stall independently without losing or duplicating data. The block sits between the data producer and the data consumer inside the data top level.

## Interface
- WIDTH, 4, data width in bits (≥1)
- DEPTH, 4, number of storage entries; power of two, ≥2
- CW (localparam), $clog2(DEPTH)+1, width of the occupancy count

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-high reset (asserted = 1); name kept for port compatibility
- s_valid  in  1  producer has a word on s_data
- s_data  in  WIDTH  producer word
- s_ready  out  1  block accepts a word this cycle
- m_valid  out  1  m_data holds a valid word
- m_data  out  WIDTH  head-of-queue word (show-ahead)
- m_ready  in  1  consumer takes the word this cycle
- count  out  CW  current occupancy, 0..DEPTH
- xfer_cnt  out  16  completed output transfers (only with DATA_HS_STATS_EN)
- stall_cnt  out  16  backpressure cycles (only with DATA_HS_STATS_EN)

## Operation
- push = s_valid & s_ready; pop = m_valid & m_ready.
- s_ready = (count != DEPTH) and reset not asserted. It depends only on registered state, so there is no combinational path from m_ready.
- m_valid = (count != 0). m_data = mem[rd_ptr]; contents are undefined-free because memory is cleared on reset.
- On push: mem[wr_ptr] <= s_data and wr_ptr increments. On pop: rd_ptr increments. Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Full (count = DEPTH): s_ready = 0, so a push is impossible. There is no write-through when full, even if m_ready = 1 that cycle.
- Empty (count = 0): m_valid = 0, so a pop is impossible. There is no bypass: a word written in cycle k is visible in cycle k+1.
- Ordering is strict FIFO. Every accepted word appears exactly once at m_data.
- Source and sink obligations:
  - Once s_valid = 1, s_data is held stable until accepted (source obligation).
  - The block holds m_data/m_valid stable until pop (sink guarantee).
- Reset mid-operation: all queued words are discarded immediately (asynchronous). Outputs take their reset values while rst_n = 1.

## Timing
- Reset values:
  - s_ready = 0, m_valid = 0, m_data = 0, count = 0
  - xfer_cnt = 0, stall_cnt = 0
  - pointers = 0, mem = 0
- First edge after rst_n deasserts: s_ready = 1.
- Latency: s_data accepted at edge k appears on m_data with m_valid = 1 after edge k (one cycle), if the FIFO was empty.
- Throughput: one word per cycle sustained in both directions when 0 < count < DEPTH, or when simultaneous push and pop occur.
- count, s_ready and m_valid all change only on clock edges, or asynchronously on reset.

## Configuration
- DATA_HS_STATS_EN defined:
  - xfer_cnt increments on every pop.
  - stall_cnt increments every cycle with m_valid = 1 and m_ready = 0.
  - Both counters saturate at 16'hFFFF and clear on reset.
- DATA_HS_STATS_EN undefined: xfer_cnt/stall_cnt ports and their logic are absent. The data path is identical in both builds.

## Test plan
- Reset then idle: with rst_n = 1, check s_ready = 0, m_valid = 0, m_data = 0, count = 0. After release: s_ready = 1, count = 0.
- Fill with m_ready = 0:
  - Push 4'h1..4'h4 (DEPTH = 4) on consecutive cycles. Check count 1, 2, 3, 4, then s_ready = 0.
  - Keep s_valid = 1 with 4'h5 for 3 more cycles. Check count stays 4 and 4'h5 is not stored.
- Drain: from full, set m_ready = 1. Check m_data reads 1, 2, 3, 4 on consecutive cycles, then m_valid = 0 and count = 0.
- Streaming with wrap:
  - Hold s_valid = m_ready = 1 for 20 cycles with incrementing data.
  - Check output equals input delayed by one cycle, count stays 1, and pointers wrap without a gap.
- Random stalls, then mid-stream reset:
  - Run 200 cycles with random s_valid/m_ready and a scoreboard. Check zero mismatches.
  - Assert rst_n with count = 3. Check m_valid = 0 and count = 0 immediately. After release, the first output is the first post-reset push.
- Stats (DATA_HS_STATS_EN):
  - 5 cycles of m_valid = 1, m_ready = 0, then 3 pops. Check stall_cnt = 5 and xfer_cnt = 3.
  - Force 70000 stall cycles. Check stall_cnt = 16'hFFFF.
